eth_tx_arbiter: RTL
===================

Name: eth_tx_arbiter

Overview:
- Shares the single Ethernet transmit datapath (RMII-style N-bit beat stream into the CRC/preamble stage) between two frame sources: the ARP responder (src0) and the IPv4/UDP sender (src1).
- Frame-granular round-robin grant, one-cycle registered data mux, and enforced inter-frame gap (IFG) between consecutive frames.
- Counterpart on TX of the RX ethertype classifier: that block splits ARP vs IPv4 on receive; this one merges them on transmit.

Parameters:
- N, 2, beat width in bits (matches RX path).
- IFG_CYCLES, 96/N (=48), idle cycles enforced after every transmitted frame.
- START_TIMEOUT, 64, max cycles a granted source may take to present its first valid beat.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- src0_req  in  1  ARP source requests the link (level, held until granted)
- src0_axiiv  in  1  ARP beat valid
- src0_axiid  in  N  ARP beat data
- src1_req  in  1  IPv4 source requests the link
- src1_axiiv  in  1  IPv4 beat valid
- src1_axiid  in  N  IPv4 beat data
- gnt  out  2  one-hot grant; bit i = source i owns the link
- axiov  out  1  muxed beat valid to TX pipeline
- axiod  out  N  muxed beat data
- busy  out  1  high in any state other than IDLE
- timeout_pulse  out  1  one-cycle pulse when a grant is revoked by START_TIMEOUT

Behaviour:
- Reset values: gnt=0, axiov=0, axiod=0, busy=0, timeout_pulse=0, state=IDLE, last_winner=1 (so src0 wins the first tie), all counters 0. Reset mid-frame: outputs 0 at the next edge, frame truncated, no IFG afterwards.
- States: IDLE, GRANT_WAIT, STREAM, IFG.
- IDLE: if any req, choose winner. Only one requesting -> that one. Both -> the source that is not last_winner. Register gnt and last_winner; go to GRANT_WAIT. gnt is visible the cycle after req is sampled.
- GRANT_WAIT: wait counter increments each cycle.
  - Granted srcX_axiiv=1 -> STREAM; that beat is forwarded.
  - Granted req drops before any beat -> IDLE next cycle, gnt=0, no IFG.
  - Counter reaches START_TIMEOUT with no beat -> gnt=0, timeout_pulse=1 for one cycle, IDLE. last_winner stays updated, so the other source gets priority next.
- STREAM: axiov/axiod <= granted source's axiiv/axiid, one-cycle latency.
  - First cycle the granted axiiv=0 ends the frame: axiov=0, gnt=0, IFG counter cleared, go to IFG.
  - No minimum or maximum frame length enforced here.
- IFG: count IFG_CYCLES cycles with axiov=0, then IDLE.
  - Requests arriving during IFG are held off, not lost, because req is level.
  - Arbitration happens in the IDLE cycle, so frame-end to next first beat is at least IFG_CYCLES+2 cycles.
- Non-granted source's axiiv/axiid are ignored in every state and never reach axiod.
- axiod is 0 whenever axiov=0.
- req held through STREAM is a don't-care. A source wanting another frame keeps or re-asserts req after its frame and is arbitrated normally (fair: the other source wins if also requesting).
- Counters are sized $clog2(max(IFG_CYCLES, START_TIMEOUT))+1 bits and saturate; there is no wrap.

Decomposition:
- Shared eth_pkg: state enum (IDLE, GRANT_WAIT, STREAM, IFG), ETH_IFG_BITS=96, ETHERTYPE_IPV4=16'h0800, ETHERTYPE_ARP=16'h0806 (shared with RX classifier).
- Sub-module rr_arbiter2: combinational 2-way round-robin pick from req[1:0] plus last_winner, producing a one-hot grant. The FSM, counters and data mux stay in eth_tx_arbiter.

Test Plan:
- Single source: src1_req=1, 40-beat frame after gnt=2'b10 -> axiov high exactly 40 cycles, axiod equals the input delayed 1 cycle, then gnt=0, busy high 48 more cycles, then busy=0.
- Tie after reset: both req=1 at once -> gnt=2'b01 first. After src0's frame plus 48 IFG cycles, gnt=2'b10. If both still request afterwards, the next grant is 2'b01.
- IFG hold-off: src0 re-asserts req 1 cycle after its frame ends -> no gnt during the 48 IFG cycles; src0 first output beat no earlier than 50 cycles after its last beat.
- Timeout: src0 granted, never drives axiiv -> exactly START_TIMEOUT=64 cycles later timeout_pulse=1 for 1 cycle, gnt=0, no IFG. Pending src1_req is granted next.
- Isolation: src1 toggles axiiv with data 2'b11 while src0 streams 2'b01 -> axiod only ever 2'b01 or 0.
- Reset mid-STREAM: rst=1 at beat 10 -> next edge axiov=0, gnt=0, busy=0. After release, a new request is granted from IDLE with no IFG delay.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: TX arbiter states and ethertype constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_WAIT = 2'd1,
    STREAM     = 2'd2,
    IFG        = 2'd3
  } tx_state_t;

  // Minimum gap between frames on the wire, expressed in bit times.
  localparam int ETH_IFG_BITS = 96;

  // Ethertypes also used by the RX classifier.
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: one-hot grant from req[1:0], ties go to the source that did not win last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is registered.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic [1:0] gnt
);

  // Single requester wins outright; on a tie the previous loser gets the link.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_winner ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Merges ARP (src0) and IPv4/UDP (src1) frames onto one TX beat stream with frame-granular round robin and enforced IFG.
// Latency: one registered cycle from granted source beat to axiov/axiod; grant visible the cycle after req is sampled.
// Backpressure: none on the beat stream; sources hold req (level) until granted, and requests during IFG simply wait.
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int N             = 2,
  parameter int IFG_CYCLES    = ETH_IFG_BITS / N,
  parameter int START_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         src0_req,
  input  logic         src0_axiiv,
  input  logic [N-1:0] src0_axiid,
  input  logic         src1_req,
  input  logic         src1_axiiv,
  input  logic [N-1:0] src1_axiid,
  output logic [1:0]   gnt,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic         busy,
  output logic         timeout_pulse
);

  localparam int CW = $clog2(max_int(IFG_CYCLES, START_TIMEOUT)) + 1;

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] TO_LAST  = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] IFG_LAST = CW'(IFG_CYCLES - 1);

  tx_state_t     state;
  logic          last_winner;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] ifg_cnt;
  logic [1:0]    pick;

  logic          sel_req;
  logic          sel_vld;
  logic [N-1:0]  sel_dat;

  rr_arbiter2 u_rr (
    .req         ({src1_req, src0_req}),
    .last_winner (last_winner),
    .gnt         (pick)
  );

  // Only the granted source is visible downstream; the other one is masked out entirely.
  always_comb begin
    sel_req = 1'b0;
    sel_vld = 1'b0;
    sel_dat = '0;
    if (gnt[1]) begin
      sel_req = src1_req;
      sel_vld = src1_axiiv;
      sel_dat = src1_axiid;
    end else if (gnt[0]) begin
      sel_req = src0_req;
      sel_vld = src0_axiiv;
      sel_dat = src0_axiid;
    end
  end

  // Arbitration FSM with registered grant, beat mux, timeout and IFG counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      gnt           <= 2'b00;
      axiov         <= 1'b0;
      axiod         <= '0;
      busy          <= 1'b0;
      timeout_pulse <= 1'b0;
      last_winner   <= 1'b1;
      wait_cnt      <= '0;
      ifg_cnt       <= '0;
    end else begin
      // Beat outputs and the pulse are single-cycle unless a state below re-asserts them.
      axiov         <= 1'b0;
      axiod         <= '0;
      timeout_pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (pick != 2'b00) begin
            gnt         <= pick;
            last_winner <= pick[1];
            wait_cnt    <= '0;
            busy        <= 1'b1;
            state       <= GRANT_WAIT;
          end
        end

        GRANT_WAIT: begin
          if (sel_vld) begin
            // First beat is forwarded immediately; a beat beats a simultaneous req drop.
            axiov <= 1'b1;
            axiod <= sel_dat;
            state <= STREAM;
          end else if (!sel_req) begin
            // Source withdrew before sending anything: nothing hit the wire, so no gap.
            gnt   <= 2'b00;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (wait_cnt >= TO_LAST) begin
            // Stalled source loses the link; last_winner already points at it, so the other side is favoured next.
            gnt           <= 2'b00;
            busy          <= 1'b0;
            timeout_pulse <= 1'b1;
            state         <= IDLE;
          end else begin
            wait_cnt <= (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
          end
        end

        STREAM: begin
          if (sel_vld) begin
            axiov <= 1'b1;
            axiod <= sel_dat;
          end else begin
            // First idle beat marks end of frame.
            gnt     <= 2'b00;
            ifg_cnt <= '0;
            state   <= IFG;
          end
        end

        IFG: begin
          if (ifg_cnt >= IFG_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            ifg_cnt <= (ifg_cnt == CNT_MAX) ? ifg_cnt : ifg_cnt + 1'b1;
          end
        end

        default: begin
          gnt   <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
